// File: rtl/mix_columns_seq.sv
// Column sequencer for AES MixColumns: walks one shared column multiplier
// over the four state columns, with a final-round bypass and output hold.
module mix_columns_seq #(
    parameter int NCOL    = 4,
    parameter int COL_W   = 32,
    parameter int STATE_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_bypass,
    output logic [COL_W-1:0]   mul_col,
    input  logic [COL_W-1:0]   mul_res,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    localparam int CNT_W = $clog2(NCOL);
    localparam int LSB_W = $clog2(STATE_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCOL - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MIX  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   col_cnt;
    logic [STATE_W-1:0] work;
    logic [LSB_W-1:0]   col_lsb;

    // Column 0 sits in the top word, so the LSB is (NCOL-1-col_cnt)*COL_W.
    assign col_lsb = {~col_cnt, 5'd0};

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign mul_col   = (state == MIX) ? work[col_lsb +: COL_W] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col_cnt   <= '0;
            work      <= '0;
            out_state <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= in_state;
                        if (in_bypass) begin
                            out_state <= in_state;
                            state     <= HOLD;
                        end else begin
                            col_cnt <= '0;
                            state   <= MIX;
                        end
                    end
                end
                MIX: begin
                    out_state[col_lsb +: COL_W] <= mul_res;
                    col_cnt <= col_cnt + CNT_W'(1);
                    if (col_cnt == LAST) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
